id_ctrl_pipe: RTL
=================

Name: id_ctrl_pipe

Overview:
- Next-generation decode-control stage for the 32I core.
- Decodes one RV32I instruction (optionally with RV32M multiply) into datapath control fields and registers them into the ID/EX pipeline register.
- Adds a valid/ready handshake, load-use hazard stall, flush, and illegal-instruction flagging.
- Sits between the IF/ID register and the EX stage.

Parameters:
- ENABLE_M, 0, when 1 decode OP with funct7=0000001 and funct3=000 (MUL) as ALU_MUL; otherwise it is illegal.
- HAZARD_EN, 1, when 1 enable load-use stall detection; when 0 the stall term is forced to 0.
- ALU_OP_W, 4, width of alu_op (minimum 4; values zero-extended).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  inst is valid
- in_ready  out  1  stage accepts inst this cycle
- inst  in  32  instruction word
- flush  in  1  kill registered and incoming instruction (branch redirect)
- ex_ready  in  1  EX consumes the registered instruction
- out_valid  out  1  registered fields are valid
- mem_read, mem_write  out  1 each  memory controls
- reg_write  out  1  register-file write, active-low
- alu_src_a, alu_src_b  out  1 each  operand selects (a: 1=rs1, 0=PC; b: 1=imm, 0=rs2)
- mem_to_reg  out  2  writeback select: 0 none, 1 mem, 2 alu
- jump  out  2  3 for JAL/JALR, else 0
- is_signed  out  1  0 for LBU/LHU/SLTU/SLTIU/BLTU/BGEU, else 1
- inst_size  out  2  00 word, 01 half, 10 byte
- alu_op  out  ALU_OP_W  ADD0 SUB1 MUL2 AND3 OR4 XOR5 SHL6 SHR7 SLT8 LUI9 BEQ10 BNE11 BGE12 BLT13
- rd, rs1, rs2  out  5 each  register indices
- illegal  out  1  registered instruction is undecodable

Behaviour:
- Reset (reset=0 at clk edge): out_valid=0, reg_write=1, all other outputs 0. Reset mid-stall drops the stalled state; in_ready reflects the new state in the first cycle after reset.
- Decode is combinational from inst. Results are registered, so latency is 1 cycle from accept to out_valid.
- Opcode and funct3 classes match the existing decoder: LUI, AUIPC, OP-IMM, LOAD, STORE, OP, BRANCH, JAL, JALR.
- AUIPC: alu_src_a=0, alu_src_b=1, ADD, mem_to_reg=2.
- All don't-care fields are driven 0 (never X).
- Inactive reg_write is 1 for STORE and BRANCH. Branches do not write.
- illegal=1 for any of:
  - unknown opcode;
  - OP funct7 not in {0000000, 0100000, 0000001 (ENABLE_M only)};
  - LOAD funct3 in {011, 110, 111};
  - STORE funct3 > 010;
  - BRANCH funct3 in {010, 011}.
- When illegal=1: reg_write=1, mem_read=0, mem_write=0, jump=0, out_valid still 1 so EX can trap.
- Advance: adv = ex_ready | ~out_valid.
- Load-use stall: stall = HAZARD_EN & out_valid & mem_read_q & (rd_q != 0) & in_valid & (rd_q == rs1 used | rd_q == rs2 used).
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by OP, STORE, BRANCH.
- in_ready = adv & ~stall & ~flush.
- Register update:
  - flush=1: out_valid<=0 (highest priority after reset).
  - Else if adv & stall: out_valid<=0 (bubble); incoming inst is held by upstream.
  - Else if adv: out_valid<=in_valid and all fields load from decode.
  - Else: hold all fields.
- A stall lasts exactly one cycle per load: the bubble clears mem_read_q's out_valid.
- Fields are loaded only when in_valid=1, to reduce toggling. When out_valid=0, out_valid alone qualifies the outputs.
- Simultaneous flush and stall: flush wins; in_ready=0.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> out_valid=0, reg_write=1, all other outputs 0.
- ADDI x1,x0,5 (0x00500093), ex_ready=1 -> next cycle out_valid=1, alu_op=0, alu_src_b=1, mem_to_reg=2, reg_write=0, rd=1.
- LW x2,0(x1) then ADD x3,x2,x1, ex_ready=1 -> in_ready=0 for 1 cycle, one bubble (out_valid=0), then ADD registered with alu_op=0, alu_src_b=0. With HAZARD_EN=0: no bubble.
- MUL x5,x6,x7 (0x027302B3) -> ENABLE_M=1: alu_op=2, illegal=0. ENABLE_M=0: illegal=1, reg_write=1.
- ex_ready=0 for 3 cycles with a valid SB registered -> outputs held (mem_write=1, inst_size=10), in_ready=0. Then flush=1 -> out_valid=0 next cycle.
- LBU (funct3=100) then BLTU (funct3=110) -> is_signed=0 with inst_size=10; then alu_op=13 with reg_write=1.

Source files
------------

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: RV32I (+ optional MUL) decode-control stage.
// Decodes the instruction combinationally and registers the control
// fields into the ID/EX register behind a valid/ready handshake. It also
// inserts a one-cycle bubble on a load-use hazard, kills the instruction on
// flush, and flags undecodable words so EX can trap.
module id_ctrl_pipe #(
    parameter bit ENABLE_M  = 1'b0,
    parameter bit HAZARD_EN = 1'b1,
    parameter int ALU_OP_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                out_valid,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          jump,
    output logic                is_signed,
    output logic [1:0]          inst_size,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3,  ALU_OR  = 4'd4,  ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6,  ALU_SHR = 4'd7,  ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9,  ALU_BEQ = 4'd10, ALU_BNE = 4'd11;
    localparam logic [3:0] ALU_BGE = 4'd12, ALU_BLT = 4'd13;

    // Shared funct3 -> ALU mapping for OP and OP-IMM (SRL/SRA both map to SHR).
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_alu = ALU_ADD;
            3'b001:  f3_alu = ALU_SHL;
            3'b010:  f3_alu = ALU_SLT;
            3'b011:  f3_alu = ALU_SLT;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = ALU_SHR;
            3'b110:  f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Decoded (next) values.
    logic       illegal_next, mem_read_next, mem_write_next, reg_write_next;
    logic       alu_src_a_next, alu_src_b_next, is_signed_next;
    logic [1:0] mem_to_reg_next, jump_next, inst_size_next;
    logic [3:0] alu_op_next;
    logic [4:0] rd_next, rs1_next, rs2_next;

    // Registered ID/EX fields.
    logic                out_valid_reg, illegal_reg, mem_read_reg, mem_write_reg;
    logic                reg_write_reg, alu_src_a_reg, alu_src_b_reg, is_signed_reg;
    logic [1:0]          mem_to_reg_reg, jump_reg, inst_size_reg;
    logic [ALU_OP_W-1:0] alu_op_reg;
    logic [4:0]          rd_reg, rs1_reg, rs2_reg;

    // Combinational decode; unused register indices are driven 0 so the
    // hazard compare never matches a source the instruction does not read.
    always_comb begin
        illegal_next    = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        reg_write_next  = 1'b1;
        alu_src_a_next  = 1'b0;
        alu_src_b_next  = 1'b0;
        mem_to_reg_next = 2'd0;
        jump_next       = 2'd0;
        is_signed_next  = 1'b1;
        inst_size_next  = 2'b00;
        alu_op_next     = ALU_ADD;
        rd_next         = 5'd0;
        rs1_next        = 5'd0;
        rs2_next        = 5'd0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                reg_write_next  = 1'b0;
                alu_src_b_next  = 1'b1;
                mem_to_reg_next = 2'd2;
                alu_op_next     = (opcode == OPC_LUI) ? ALU_LUI : ALU_ADD;
                rd_next         = inst[11:7];
            end
            OPC_OP_IMM: begin
                reg_write_next  = 1'b0;
                alu_src_a_next  = 1'b1;
                alu_src_b_next  = 1'b1;
                mem_to_reg_next = 2'd2;
                alu_op_next     = f3_alu(funct3);
                is_signed_next  = (funct3 != 3'b011);
                rd_next         = inst[11:7];
                rs1_next        = inst[19:15];
            end
            OPC_LOAD: begin
                reg_write_next  = 1'b0;
                mem_read_next   = 1'b1;
                alu_src_a_next  = 1'b1;
                alu_src_b_next  = 1'b1;
                mem_to_reg_next = 2'd1;
                rd_next         = inst[11:7];
                rs1_next        = inst[19:15];
                case (funct3)
                    3'b000:  inst_size_next = 2'b10;
                    3'b001:  inst_size_next = 2'b01;
                    3'b010:  inst_size_next = 2'b00;
                    3'b100:  begin inst_size_next = 2'b10; is_signed_next = 1'b0; end
                    3'b101:  begin inst_size_next = 2'b01; is_signed_next = 1'b0; end
                    default: illegal_next = 1'b1;
                endcase
            end
            OPC_STORE: begin
                mem_write_next = 1'b1;
                alu_src_a_next = 1'b1;
                alu_src_b_next = 1'b1;
                rs1_next       = inst[19:15];
                rs2_next       = inst[24:20];
                case (funct3)
                    3'b000:  inst_size_next = 2'b10;
                    3'b001:  inst_size_next = 2'b01;
                    3'b010:  inst_size_next = 2'b00;
                    default: illegal_next = 1'b1;
                endcase
            end
            OPC_OP: begin
                reg_write_next  = 1'b0;
                alu_src_a_next  = 1'b1;
                mem_to_reg_next = 2'd2;
                rd_next         = inst[11:7];
                rs1_next        = inst[19:15];
                rs2_next        = inst[24:20];
                is_signed_next  = (funct3 != 3'b011);
                case (funct7)
                    7'b0000000: alu_op_next = f3_alu(funct3);
                    7'b0100000: alu_op_next = (funct3 == 3'b000) ? ALU_SUB : f3_alu(funct3);
                    7'b0000001: begin
                        if (ENABLE_M && funct3 == 3'b000) alu_op_next = ALU_MUL;
                        else                              illegal_next = 1'b1;
                    end
                    default:    illegal_next = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                alu_src_a_next = 1'b1;
                rs1_next       = inst[19:15];
                rs2_next       = inst[24:20];
                case (funct3)
                    3'b000:  alu_op_next = ALU_BEQ;
                    3'b001:  alu_op_next = ALU_BNE;
                    3'b100:  alu_op_next = ALU_BLT;
                    3'b101:  alu_op_next = ALU_BGE;
                    3'b110:  begin alu_op_next = ALU_BLT; is_signed_next = 1'b0; end
                    3'b111:  begin alu_op_next = ALU_BGE; is_signed_next = 1'b0; end
                    default: illegal_next = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                reg_write_next  = 1'b0;
                alu_src_a_next  = (opcode == OPC_JALR);
                alu_src_b_next  = 1'b1;
                mem_to_reg_next = 2'd2;
                jump_next       = 2'd3;
                rd_next         = inst[11:7];
                rs1_next        = (opcode == OPC_JALR) ? inst[19:15] : 5'd0;
            end
            default: illegal_next = 1'b1;
        endcase
        // An undecodable word must not write, touch memory or jump.
        if (illegal_next) begin
            mem_read_next   = 1'b0;
            mem_write_next  = 1'b0;
            reg_write_next  = 1'b1;
            alu_src_a_next  = 1'b0;
            alu_src_b_next  = 1'b0;
            mem_to_reg_next = 2'd0;
            jump_next       = 2'd0;
            is_signed_next  = 1'b1;
            inst_size_next  = 2'b00;
            alu_op_next     = ALU_ADD;
            rd_next         = 5'd0;
            rs1_next        = 5'd0;
            rs2_next        = 5'd0;
        end
    end

    // Load-use hazard: incoming source index equals the registered load's rd.
    logic [4:0] src_idx [2];
    logic [1:0] src_hit;
    logic       adv, stall;
    assign src_idx[0] = rs1_next;
    assign src_idx[1] = rs2_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_hit
            assign src_hit[gi] = (src_idx[gi] == rd_reg);
        end
        if (HAZARD_EN) begin : g_hazard
            assign stall = out_valid_reg & mem_read_reg & (rd_reg != 5'd0) & in_valid & (|src_hit);
        end else begin : g_no_hazard
            assign stall = 1'b0;
        end
    endgenerate

    assign adv      = ex_ready | ~out_valid_reg;
    assign in_ready = adv & ~stall & ~flush;

    // ID/EX register: reset, then flush, then bubble, then load or hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_reg  <= 1'b0;
            illegal_reg    <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            reg_write_reg  <= 1'b1;
            alu_src_a_reg  <= 1'b0;
            alu_src_b_reg  <= 1'b0;
            mem_to_reg_reg <= 2'd0;
            jump_reg       <= 2'd0;
            is_signed_reg  <= 1'b0;
            inst_size_reg  <= 2'b00;
            alu_op_reg     <= '0;
            rd_reg         <= 5'd0;
            rs1_reg        <= 5'd0;
            rs2_reg        <= 5'd0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (adv && stall) begin
            out_valid_reg <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                illegal_reg    <= illegal_next;
                mem_read_reg   <= mem_read_next;
                mem_write_reg  <= mem_write_next;
                reg_write_reg  <= reg_write_next;
                alu_src_a_reg  <= alu_src_a_next;
                alu_src_b_reg  <= alu_src_b_next;
                mem_to_reg_reg <= mem_to_reg_next;
                jump_reg       <= jump_next;
                is_signed_reg  <= is_signed_next;
                inst_size_reg  <= inst_size_next;
                alu_op_reg     <= ALU_OP_W'(alu_op_next);
                rd_reg         <= rd_next;
                rs1_reg        <= rs1_next;
                rs2_reg        <= rs2_next;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign illegal    = illegal_reg;
    assign mem_read   = mem_read_reg;
    assign mem_write  = mem_write_reg;
    assign reg_write  = reg_write_reg;
    assign alu_src_a  = alu_src_a_reg;
    assign alu_src_b  = alu_src_b_reg;
    assign mem_to_reg = mem_to_reg_reg;
    assign jump       = jump_reg;
    assign is_signed  = is_signed_reg;
    assign inst_size  = inst_size_reg;
    assign alu_op     = alu_op_reg;
    assign rd         = rd_reg;
    assign rs1        = rs1_reg;
    assign rs2        = rs2_reg;

endmodule
